// File: rtl/frank6000_stack_pkg.sv
// rtl/frank6000_stack_pkg.sv - shared constants and op decode for the return address stack
package frank6000_stack_pkg;

  localparam int OVF_REJECT = 0;
  localparam int OVF_WRAP   = 1;

  // Encoding mirrors {i_call, i_rtrn} so decode is a plain cast.
  typedef enum logic [1:0] {
    STK_NOP  = 2'b00,
    STK_POP  = 2'b01,
    STK_PUSH = 2'b10,
    STK_REPL = 2'b11
  } stk_op_e;

  function automatic stk_op_e decode_op(input logic call, input logic rtrn);
    return stk_op_e'({call, rtrn});
  endfunction

endpackage

// File: rtl/stack_regfile.sv
// rtl/stack_regfile.sv - register array with async-clear, one sync write port and one async read port
module stack_regfile #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/return_address_stack.sv
// rtl/return_address_stack.sv - call/return address stack with status, overflow policy and sticky error flags
module return_address_stack
  import frank6000_stack_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int PC_INCR    = 1,
  parameter int OVF_MODE   = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_PC,
  input  logic                  i_call,
  input  logic                  i_rtrn,
  input  logic                  i_clr_err,
  output logic [DATA_WIDTH-1:0] o_stack,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_ovf,
  output logic                  o_unf
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] top_q, top_d, bot_q, bot_d, top_m1;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  ovf_set, unf_set, do_push, empty, full;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] push_val, rdata;
  stk_op_e               op;

  assign op       = decode_op(i_call, i_rtrn);
  assign push_val = i_PC + DATA_WIDTH'(PC_INCR);
  assign top_m1   = top_q - ADDR_WIDTH'(1);
  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_COUNT);
  // A combined call+rtrn on an empty stack has nothing to replace, so it pushes.
  assign do_push  = (op == STK_PUSH) || (op == STK_REPL && empty);

  always_comb begin
    top_d   = top_q;
    bot_d   = bot_q;
    count_d = count_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    we      = 1'b0;
    waddr   = top_q;
    if (do_push) begin
      if (!full) begin
        we      = 1'b1;
        top_d   = top_q + ADDR_WIDTH'(1);
        count_d = count_q + (ADDR_WIDTH+1)'(1);
      end else begin
        ovf_set = 1'b1;
        if (OVF_MODE == OVF_WRAP) begin
          we    = 1'b1;
          top_d = top_q + ADDR_WIDTH'(1);
          bot_d = bot_q + ADDR_WIDTH'(1);
        end
      end
    end else if (op == STK_POP) begin
      if (!empty) begin
        top_d   = top_m1;
        count_d = count_q - (ADDR_WIDTH+1)'(1);
      end else begin
        unf_set = 1'b1;
      end
    end else if (op == STK_REPL) begin
      we    = 1'b1;
      waddr = top_m1;
    end
    ovf_d = ovf_set | (ovf_q & ~i_clr_err);
    unf_d = unf_set | (unf_q & ~i_clr_err);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      top_q   <= '0;
      bot_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      bot_q   <= bot_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  stack_regfile #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_regfile (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (we),
    .i_waddr (waddr),
    .i_wdata (push_val),
    .i_raddr (top_m1),
    .o_rdata (rdata)
  );

  assign o_stack = empty ? '0 : rdata;
  assign o_count = count_q;
  assign o_empty = empty;
  assign o_full  = full;
  assign o_ovf   = ovf_q;
  assign o_unf   = unf_q;

endmodule

// File: tb/tb_return_address_stack.sv
// tb/tb_return_address_stack.sv - directed bench driving a reject-mode and a wrap-mode stack in lockstep
module tb_return_address_stack;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pc = '0;
  logic       call = 1'b0, rtrn = 1'b0, clr = 1'b0;

  logic [7:0] r_stack, w_stack;
  logic [2:0] r_count, w_count;
  logic       r_empty, r_full, r_ovf, r_unf;
  logic       w_empty, w_full, w_ovf, w_unf;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  return_address_stack #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .PC_INCR(1), .OVF_MODE(0)) dut_r (
    .i_clk(clk), .i_rst_n(rst_n), .i_PC(pc), .i_call(call), .i_rtrn(rtrn), .i_clr_err(clr),
    .o_stack(r_stack), .o_count(r_count), .o_empty(r_empty), .o_full(r_full),
    .o_ovf(r_ovf), .o_unf(r_unf)
  );

  return_address_stack #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .PC_INCR(1), .OVF_MODE(1)) dut_w (
    .i_clk(clk), .i_rst_n(rst_n), .i_PC(pc), .i_call(call), .i_rtrn(rtrn), .i_clr_err(clr),
    .o_stack(w_stack), .o_count(w_count), .o_empty(w_empty), .o_full(w_full),
    .o_ovf(w_ovf), .o_unf(w_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic c, input logic r, input logic [7:0] p, input logic cl);
    call = c; rtrn = r; pc = p; clr = cl;
    @(posedge clk);
    #1;
    call = 1'b0; rtrn = 1'b0; pc = '0; clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_empty_r", r_empty, 1);  chk("rst_empty_w", w_empty, 1);
    chk("rst_full_r", r_full, 0);    chk("rst_full_w", w_full, 0);
    chk("rst_count_r", r_count, 0);  chk("rst_count_w", w_count, 0);
    chk("rst_stack_r", r_stack, 8'h00);
    chk("rst_ovf_r", r_ovf, 0);      chk("rst_unf_r", r_unf, 0);
    chk("rst_ovf_w", w_ovf, 0);      chk("rst_unf_w", w_unf, 0);

    step(1, 0, 8'h10, 0);
    step(1, 0, 8'h20, 0);
    chk("call2_stack", r_stack, 8'h21);
    chk("call2_count", r_count, 2);
    step(0, 1, 8'h00, 0);
    chk("rtrn1_stack", r_stack, 8'h11);
    step(0, 1, 8'h00, 0);
    chk("rtrn2_empty", r_empty, 1);
    chk("rtrn2_stack", r_stack, 8'h00);

    do_reset();
    step(1, 0, 8'h01, 0);
    step(1, 0, 8'h02, 0);
    step(1, 0, 8'h03, 0);
    step(1, 0, 8'h04, 0);
    chk("fill_full", r_full, 1);
    chk("fill_ovf", r_ovf, 0);
    chk("fill_stack", w_stack, 8'h05);
    step(1, 0, 8'h09, 0);
    chk("rej_full", r_full, 1);
    chk("rej_count", r_count, 4);
    chk("rej_stack", r_stack, 8'h05);
    chk("rej_ovf", r_ovf, 1);
    chk("wrap_full", w_full, 1);
    chk("wrap_count", w_count, 4);
    chk("wrap_stack", w_stack, 8'h0A);
    chk("wrap_ovf", w_ovf, 1);
    chk("pop0_r", r_stack, 8'h05); chk("pop0_w", w_stack, 8'h0A);
    step(0, 1, 8'h00, 0);
    chk("pop1_r", r_stack, 8'h04); chk("pop1_w", w_stack, 8'h05);
    step(0, 1, 8'h00, 0);
    chk("pop2_r", r_stack, 8'h03); chk("pop2_w", w_stack, 8'h04);
    step(0, 1, 8'h00, 0);
    chk("pop3_r", r_stack, 8'h02); chk("pop3_w", w_stack, 8'h03);
    step(0, 1, 8'h00, 0);
    chk("pop4_empty_r", r_empty, 1); chk("pop4_empty_w", w_empty, 1);
    chk("pop4_stack_w", w_stack, 8'h00);

    step(0, 1, 8'h00, 0);
    chk("unf_set", r_unf, 1);
    chk("unf_count", r_count, 0);
    chk("unf_stack", r_stack, 8'h00);
    chk("unf_ovf_held", w_ovf, 1);
    step(0, 0, 8'h00, 1);
    chk("clr_unf", r_unf, 0);
    chk("clr_ovf", w_ovf, 0);
    step(0, 1, 8'h00, 1);
    chk("clr_vs_unf", r_unf, 1);

    do_reset();
    chk("rst2_unf", r_unf, 0);
    step(1, 0, 8'h10, 0);
    step(1, 0, 8'h20, 0);
    chk("pre_repl_stack", r_stack, 8'h21);
    step(1, 1, 8'h40, 0);
    chk("repl_stack", r_stack, 8'h41);
    chk("repl_count", r_count, 2);
    chk("repl_ovf", r_ovf, 0);
    chk("repl_unf", r_unf, 0);
    step(1, 0, 8'hFF, 0);
    chk("pc_wrap_stack", r_stack, 8'h00);
    chk("pc_wrap_count", r_count, 3);
    chk("pc_wrap_empty", r_empty, 0);

    #2;
    rst_n = 1'b0;
    #1;
    chk("async_count", r_count, 0);
    chk("async_empty", r_empty, 1);
    chk("async_stack", r_stack, 8'h00);
    rst_n = 1'b1;
    #1;

    step(1, 1, 8'h30, 0);
    chk("repl_empty_stack", r_stack, 8'h31);
    chk("repl_empty_count", r_count, 1);
    step(0, 1, 8'h00, 0);
    chk("after_repl_pop", r_empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
